// File: rtl/dm_pkg.sv
// dm_pkg: shared types and access helpers for the data-memory controller
package dm_pkg;
    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    typedef enum logic {IDLE, SECOND} dm_state_e;

    function automatic logic [2:0] size_of(logic [2:0] ctrl);
        return ctrl inside {DM_B, DM_BU} ? 3'd1 : ctrl inside {DM_H, DM_HU} ? 3'd2 : 3'd4;
    endfunction

    function automatic logic [3:0] be_of(logic [2:0] size);
        return size == 3'd1 ? 4'b0001 : size == 3'd2 ? 4'b0011 : 4'b1111;
    endfunction

    function automatic logic [31:0] extend(logic [2:0] ctrl, logic [31:0] raw);
        return ctrl == DM_B  ? {{24{raw[7]}}, raw[7:0]} :
               ctrl == DM_H  ? {{16{raw[15]}}, raw[15:0]} :
               ctrl == DM_BU ? {24'b0, raw[7:0]} :
               ctrl == DM_HU ? {16'b0, raw[15:0]} : raw;
    endfunction
endpackage

// File: rtl/dm_bank.sv
// dm_bank: byte-enabled synchronous-read word array with a combinational debug tap
module dm_bank #(
    parameter int DEPTH_WORDS = 256,
    parameter int DEBUG_WORDS = 8,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [AW-1:0]                addr_i,
    input  logic [3:0]                   be_i,
    input  logic [31:0]                  wdata_i,
    output logic [31:0]                  rdata_o,
    output logic [DEBUG_WORDS-1:0][31:0] debug_o
);
    // No INIT contents: block RAM comes up all-zero after configuration
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

    for (genvar i = 0; i < DEBUG_WORDS; i++) begin : g_dbg
        assign debug_o[i] = mem_q[i];
    end
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: rv32i data-memory controller; word-crossing accesses are split or rejected
module dm_ctrl import dm_pkg::*; #(
    parameter int DEPTH_WORDS      = 256,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int DEBUG_WORDS      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [2:0]                   req_ctrl,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic [DEBUG_WORDS-1:0][31:0] debug_word
);
    localparam int AW = $clog2(DEPTH_WORDS);

    dm_state_e   state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_load_q, rsp_load_d;
    logic        we_q, split_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q;
    logic [AW-1:0] word_q;
    logic [31:0] wdata_q, low_q;
    logic        idle, accept, illegal, misaligned, crossing, err, split;
    logic [2:0]  size;
    logic [7:0]  be8;
    logic [63:0] data64, raw64;
    logic [31:0] merged;
    logic        bank_we;
    logic [AW-1:0] bank_addr;
    logic [3:0]  bank_be;
    logic [31:0] bank_wdata, bank_rdata;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    dm_bank #(.DEPTH_WORDS(DEPTH_WORDS), .DEBUG_WORDS(DEBUG_WORDS)) u_bank (
        .clk_i   (clk),
        .we_i    (bank_we),
        .addr_i  (bank_addr),
        .be_i    (bank_be),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata),
        .debug_o (debug_word)
    );

    always_comb begin
        idle       = state_q == IDLE;
        size       = size_of(req_ctrl);
        illegal    = req_we ? (req_ctrl > 3'd2) : (req_ctrl inside {3'b011, 3'b110, 3'b111});
        misaligned = (req_addr[1:0] & 2'(size - 3'd1)) != 2'd0;
        crossing   = {1'b0, req_addr[1:0]} + size > 3'd4;
        err        = illegal || (!SPLIT_MISALIGNED && misaligned);
        split      = SPLIT_MISALIGNED && crossing && !err;
        accept     = req_valid && idle && !rst;
        // Lanes as a 64-bit window over words w and w+1; a single access only uses the low half
        be8        = {4'b0, be_of(size_of(idle ? req_ctrl : ctrl_q))} << (idle ? req_addr[1:0] : off_q);
        data64     = {32'b0, (idle ? req_wdata : wdata_q)} << {(idle ? req_addr[1:0] : off_q), 3'b000};
        bank_we    = idle ? (accept && req_we && !err) : (we_q && !rst);
        bank_addr  = idle ? req_addr[AW+1:2] : word_q + AW'(1);
        bank_be    = idle ? be8[3:0] : be8[7:4];
        bank_wdata = idle ? data64[31:0] : data64[63:32];
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_load_d  = 1'b0;
        if (!idle) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_load_d  = !we_q;
        end else if (accept) begin
            state_d     = split ? SECOND : IDLE;
            rsp_valid_d = !split;
            rsp_err_d   = err;
            rsp_load_d  = !split && !err && !req_we;
        end
        raw64     = split_q ? {bank_rdata, low_q} : {32'b0, bank_rdata};
        merged    = 32'(raw64 >> {off_q, 3'b000});
        rsp_rdata = rsp_load_q ? extend(ctrl_q, merged) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
        end
        if (accept) begin
            ctrl_q  <= req_ctrl;
            off_q   <= req_addr[1:0];
            we_q    <= req_we;
            word_q  <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            split_q <= split;
        end
        if (!idle) low_q <= bank_rdata;
    end

    assign req_ready = idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: randomized and directed checks of dm_ctrl against a byte-level memory model
module tb_dm_ctrl;
    localparam int DEPTH = 256, DBG = 8, NB = 4 * DEPTH;

    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid, rsp_err;
    logic [2:0] req_ctrl [2];
    logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
    logic [DBG-1:0][31:0] dbg [2];
    logic [7:0] mm [2][NB];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    // index 1: split variant, index 0: error-on-misaligned variant
    dm_ctrl #(.DEPTH_WORDS(DEPTH), .SPLIT_MISALIGNED(1'b1), .DEBUG_WORDS(DBG)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_ctrl(req_ctrl[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .debug_word(dbg[1]));
    dm_ctrl #(.DEPTH_WORDS(DEPTH), .SPLIT_MISALIGNED(1'b0), .DEBUG_WORDS(DBG)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_ctrl(req_ctrl[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .debug_word(dbg[0]));

    function automatic void model(input int s, input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd, output logic err, output int lat);
        int sz = ctrl[1:0] == 2'd0 ? 1 : ctrl[1:0] == 2'd1 ? 2 : 4;
        int off = int'(addr[1:0]);
        logic legal = we ? (ctrl <= 3'd2) : !(ctrl inside {3'd3, 3'd6, 3'd7});
        logic [31:0] raw = '0;
        err = !legal || (s == 0 && off % sz != 0);
        lat = (!err && s == 1 && off + sz > 4) ? 2 : 1;
        rd = '0;
        if (err) return;
        for (int k = 0; k < sz; k++) begin
            int b = int'((addr + 32'(k)) % NB);
            if (we) mm[s][b] = wdata[8*k +: 8];
            else raw[8*k +: 8] = mm[s][b];
        end
        if (!we) rd = (ctrl[2] || sz == 4) ? raw : sz == 1 ? {{24{raw[7]}}, raw[7:0]} : {{16{raw[15]}}, raw[15:0]};
    endfunction

    function automatic logic [31:0] model_word(input int s, input int w);
        return {mm[s][4*w+3], mm[s][4*w+2], mm[s][4*w+1], mm[s][4*w]};
    endfunction

    task automatic access(input int s, input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                          output int lat, output logic rdy);
        @(negedge clk);
        req_valid[s] = 1'b1; req_we[s] = we; req_ctrl[s] = ctrl; req_addr[s] = addr; req_wdata[s] = wdata;
        @(negedge clk);
        req_valid[s] = 1'b0;
        lat = 1;
        rdy = req_ready[s];
        while (!rsp_valid[s] && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata[s];
        err = rsp_err[s];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks += 4;
            if (req_ready[s] !== 1'b1) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=1", s, req_ready[s]); end
            if (rsp_valid[s] !== 1'b0) begin failures++; $display("FAIL reset_valid[%0d] got=%b exp=0", s, rsp_valid[s]); end
            if (rsp_err[s] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got=%b exp=0", s, rsp_err[s]); end
            if (rsp_rdata[s] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", s, rsp_rdata[s]); end
        end
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        logic [31:0] rd, erd; logic err, eerr, rdy; int lat, elat;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH; w++) begin
                access(s, 1'b1, 3'b010, 32'(4 * w), 32'h0, rd, err, lat, rdy);
                model(s, 1'b1, 3'b010, 32'(4 * w), 32'h0, erd, eerr, elat);
            end
    endtask

    task automatic test_aligned();
        logic [2:0]  t_ctrl [6] = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] t_addr [6] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] t_exp  [6] = '{32'h0, 32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        logic [31:0] rd, erd; logic err, eerr, rdy; int lat, elat;
        for (int i = 0; i < 6; i++) begin
            access(1, i == 0, t_ctrl[i], t_addr[i], 32'hDEADBEEF, rd, err, lat, rdy);
            model(1, i == 0, t_ctrl[i], t_addr[i], 32'hDEADBEEF, erd, eerr, elat);
            checks += 3;
            if (rd !== t_exp[i]) begin failures++; $display("FAIL aligned_rdata[%0d] got=%h exp=%h", i, rd, t_exp[i]); end
            if (err !== 1'b0) begin failures++; $display("FAIL aligned_err[%0d] got=%b exp=0", i, err); end
            if (lat != 1) begin failures++; $display("FAIL aligned_latency[%0d] got=%0d exp=1", i, lat); end
        end
        checks++;
        if (dbg[1][4] !== 32'hDEADBEEF) begin failures++; $display("FAIL debug_word4 got=%h exp=deadbeef", dbg[1][4]); end
    endtask

    task automatic test_split();
        logic [31:0] rd, erd; logic err, eerr, rdy; int lat, elat;
        access(1, 1'b1, 3'b010, 32'h1E, 32'h11223344, rd, err, lat, rdy);
        model(1, 1'b1, 3'b010, 32'h1E, 32'h11223344, erd, eerr, elat);
        checks += 6;
        if (lat != 2) begin failures++; $display("FAIL split_sw_latency got=%0d exp=2", lat); end
        if (rdy !== 1'b0) begin failures++; $display("FAIL split_sw_ready got=%b exp=0", rdy); end
        if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL split_sw_rsp got=%h/%b exp=0/0", rd, err); end
        if (dbg[1][7][31:16] !== 16'h3344) begin failures++; $display("FAIL split_word7_hi got=%h exp=3344", dbg[1][7][31:16]); end
        if (dbg[1][7] !== model_word(1, 7)) begin failures++; $display("FAIL split_word7 got=%h exp=%h", dbg[1][7], model_word(1, 7)); end
        access(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, err, lat, rdy);
        if (rd !== 32'h00001122) begin failures++; $display("FAIL split_word8 got=%h exp=00001122", rd); end
        access(1, 1'b0, 3'b010, 32'h1E, 32'h0, rd, err, lat, rdy);
        checks += 2;
        if (rd !== 32'h11223344) begin failures++; $display("FAIL split_lw_rdata got=%h exp=11223344", rd); end
        if (lat != 2 || err !== 1'b0) begin failures++; $display("FAIL split_lw_lat_err got=%0d/%b exp=2/0", lat, err); end
        access(1, 1'b0, 3'b001, 32'h11, 32'h0, rd, err, lat, rdy);
        model(1, 1'b0, 3'b001, 32'h11, 32'h0, erd, eerr, elat);
        checks++;
        if (rd !== erd || lat != elat) begin failures++; $display("FAIL split_lh_off1 got=%h/%0d exp=%h/%0d", rd, lat, erd, elat); end
    endtask

    task automatic test_nosplit();
        logic        t_we   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  t_ctrl [6] = '{3'b010, 3'b010, 3'b001, 3'b101, 3'b001, 3'b001};
        logic [31:0] t_addr [6] = '{32'h04, 32'h06, 32'h03, 32'h08, 32'h05, 32'h06};
        logic [31:0] rd, erd; logic err, eerr, rdy; int lat, elat;
        for (int i = 0; i < 6; i++) begin
            access(0, t_we[i], t_ctrl[i], t_addr[i], 32'h55667788, rd, err, lat, rdy);
            model(0, t_we[i], t_ctrl[i], t_addr[i], 32'h55667788, erd, eerr, elat);
            checks += 3;
            if (rd !== erd) begin failures++; $display("FAIL nosplit_rdata[%0d] got=%h exp=%h", i, rd, erd); end
            if (err !== eerr) begin failures++; $display("FAIL nosplit_err[%0d] got=%b exp=%b", i, err, eerr); end
            if (lat != 1) begin failures++; $display("FAIL nosplit_latency[%0d] got=%0d exp=1", i, lat); end
        end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (dbg[0][w] !== model_word(0, w)) begin failures++; $display("FAIL nosplit_mem[%0d] got=%h exp=%h", w, dbg[0][w], model_word(0, w)); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, erd; logic err, eerr, rdy; int lat, elat;
        access(1, 1'b1, 3'b010, 32'h3FE, 32'hCAFEF00D, rd, err, lat, rdy);
        model(1, 1'b1, 3'b010, 32'h3FE, 32'hCAFEF00D, erd, eerr, elat);
        checks += 2;
        if (lat != 2) begin failures++; $display("FAIL wrap_latency got=%0d exp=2", lat); end
        if (dbg[1][0][15:0] !== 16'hCAFE) begin failures++; $display("FAIL wrap_word0 got=%h exp=cafe", dbg[1][0][15:0]); end
        access(1, 1'b0, 3'b010, 32'h3FC, 32'h0, rd, err, lat, rdy);
        model(1, 1'b0, 3'b010, 32'h3FC, 32'h0, erd, eerr, elat);
        checks++;
        if (rd !== erd) begin failures++; $display("FAIL wrap_top_word got=%h exp=%h", rd, erd); end
        access(1, 1'b0, 3'b010, 32'h400, 32'h0, rd, err, lat, rdy);
        model(1, 1'b0, 3'b010, 32'h400, 32'h0, erd, eerr, elat);
        checks++;
        if (rd !== erd) begin failures++; $display("FAIL wrap_lw_400 got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d = $urandom(), erd; logic eerr; int elat;
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_ctrl[1] = 3'b010; req_addr[1] = 32'h28; req_wdata[1] = d;
        @(negedge clk);
        checks += 2;
        if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready[1]); end
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h0) begin failures++; $display("FAIL b2b_store_rsp got=%b/%h exp=1/0", rsp_valid[1], rsp_rdata[1]); end
        req_we[1] = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b0;
        model(1, 1'b1, 3'b010, 32'h28, d, erd, eerr, elat);
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== d || rsp_err[1] !== 1'b0)
            begin failures++; $display("FAIL b2b_load got=%b/%h/%b exp=1/%h/0", rsp_valid[1], rsp_rdata[1], rsp_err[1], d); end
    endtask

    task automatic test_reset_mid_split();
        logic [31:0] rd, erd; logic err, eerr, rdy; int lat, elat;
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_ctrl[1] = 3'b010; req_addr[1] = 32'h1E; req_wdata[1] = 32'hA1B2C3D4;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mm[1][32'h1E] = 8'hD4;
        mm[1][32'h1F] = 8'hC3;
        checks += 3;
        if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL midsplit_valid got=%b exp=0", rsp_valid[1]); end
        if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL midsplit_ready got=%b exp=1", req_ready[1]); end
        if (dbg[1][7] !== model_word(1, 7)) begin failures++; $display("FAIL midsplit_word7 got=%h exp=%h", dbg[1][7], model_word(1, 7)); end
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL midsplit_late_rsp got=%b exp=0", rsp_valid[1]); end
        access(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, err, lat, rdy);
        model(1, 1'b0, 3'b010, 32'h20, 32'h0, erd, eerr, elat);
        checks++;
        if (rd !== erd) begin failures++; $display("FAIL midsplit_word8 got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_reset_with_valid();
        @(negedge clk);
        rst = 1'b1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_ctrl[1] = 3'b010; req_addr[1] = 32'h04; req_wdata[1] = 32'h99999999;
        @(negedge clk);
        rst = 1'b0;
        req_valid[1] = 1'b0;
        checks += 2;
        if (dbg[1][1] !== model_word(1, 1)) begin failures++; $display("FAIL rstvalid_word1 got=%h exp=%h", dbg[1][1], model_word(1, 1)); end
        if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL rstvalid_rsp got=%b exp=0", rsp_valid[1]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd; logic err, eerr, rdy, we; logic [2:0] ctrl; int lat, elat;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 150; n++) begin
                we = 1'($urandom_range(0, 1));
                ctrl = 3'($urandom_range(0, 7));
                addr = $urandom();
                addr[9:0] = ($urandom_range(0, 3) == 0) ? 10'(1016 + $urandom_range(0, 7)) : 10'($urandom_range(0, 47));
                wd = $urandom();
                access(s, we, ctrl, addr, wd, rd, err, lat, rdy);
                model(s, we, ctrl, addr, wd, erd, eerr, elat);
                checks += 4;
                if (rd !== erd) begin failures++; $display("FAIL rand_rdata[%0d.%0d] we=%b ctrl=%b addr=%h got=%h exp=%h", s, n, we, ctrl, addr, rd, erd); end
                if (err !== eerr) begin failures++; $display("FAIL rand_err[%0d.%0d] got=%b exp=%b", s, n, err, eerr); end
                if (lat != elat) begin failures++; $display("FAIL rand_latency[%0d.%0d] got=%0d exp=%0d", s, n, lat, elat); end
                if (rdy !== (elat == 1)) begin failures++; $display("FAIL rand_ready[%0d.%0d] got=%b exp=%b", s, n, rdy, elat == 1); end
            end
            for (int w = 0; w < DBG; w++) begin
                checks++;
                if (dbg[s][w] !== model_word(s, w)) begin failures++; $display("FAIL rand_debug[%0d.%0d] got=%h exp=%h", s, w, dbg[s][w], model_word(s, w)); end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_ctrl[s] = '0; req_addr[s] = '0; req_wdata[s] = '0;
            for (int b = 0; b < NB; b++) mm[s][b] = 8'h0;
        end
        test_reset();
        clear_mem();
        test_aligned();
        test_split();
        test_nosplit();
        test_wrap();
        test_back_to_back();
        test_reset_mid_split();
        test_reset_with_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end
endmodule
